// File: rtl/kyber_coder_pkg.sv
// Shared definitions for the Kyber coder sequencer: coder modes, request ops,
// FSM states and per-mode working-cycle budgets.
package kyber_coder_pkg;

  typedef enum logic [3:0] {
    MODE_WAIT   = 4'd0,
    MODE_ENC_SK = 4'd1,
    MODE_ENC_PK = 4'd2,
    MODE_DEC_PK = 4'd3,
    MODE_DEC_M  = 4'd4,
    MODE_ENC_CT = 4'd5,
    MODE_DEC_SK = 4'd6,
    MODE_DEC_CT = 4'd7,
    MODE_ENC_M  = 4'd8
  } coder_mode_e;

  typedef enum logic [2:0] {
    OP_KEYGEN_OUT = 3'd0,
    OP_ENC_IN     = 3'd1,
    OP_ENC_OUT    = 3'd2,
    OP_DEC_IN     = 3'd3,
    OP_DEC_OUT    = 3'd4
  } req_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } seq_state_e;

  localparam logic [6:0] W_FULL = 7'd64;
  localparam logic [6:0] W_MSG  = 7'd33;
  localparam logic [6:0] W_CT   = 7'd97;

  function automatic logic [6:0] mode_work_cycles(input logic [3:0] mode);
    logic [6:0] w;
    case (mode)
      MODE_ENC_SK, MODE_ENC_PK, MODE_DEC_PK, MODE_DEC_SK: w = W_FULL;
      MODE_DEC_M, MODE_ENC_M:                             w = W_MSG;
      MODE_ENC_CT, MODE_DEC_CT:                           w = W_CT;
      default:                                            w = 7'd0;
    endcase
    return w;
  endfunction

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= 3'd4);
  endfunction

endpackage

// File: rtl/coder_step_rom.sv
// Step lists per high-level op: which load precedes the first mode, the mode
// for each step index, and whether that step is the final one.
module coder_step_rom
  import kyber_coder_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic [1:0] i_step,
  output logic       o_has_load,
  output logic       o_load_is_dec,
  output logic [3:0] o_mode,
  output logic       o_is_last
);

  // Table lookup; unused step slots decode to WAIT and terminate the op.
  always_comb begin
    o_has_load    = 1'b0;
    o_load_is_dec = 1'b0;
    o_mode        = MODE_WAIT;
    o_is_last     = 1'b1;
    case (i_op)
      OP_KEYGEN_OUT: begin
        o_mode    = (i_step == 2'd0) ? MODE_ENC_SK : MODE_ENC_PK;
        o_is_last = (i_step != 2'd0);
      end
      OP_ENC_IN: begin
        o_has_load = 1'b1;
        o_mode     = (i_step == 2'd0) ? MODE_DEC_PK : MODE_DEC_M;
        o_is_last  = (i_step != 2'd0);
      end
      OP_ENC_OUT: begin
        o_mode = MODE_ENC_CT;
      end
      OP_DEC_IN: begin
        o_has_load    = 1'b1;
        o_load_is_dec = 1'b1;
        o_mode        = (i_step == 2'd0) ? MODE_DEC_SK : MODE_DEC_CT;
        o_is_last     = (i_step != 2'd0);
      end
      OP_DEC_OUT: begin
        o_mode = MODE_ENC_M;
      end
      default: begin
        o_mode = MODE_WAIT;
      end
    endcase
  end

endmodule

// File: rtl/coder_seq.sv
// Sequences the coder for one high-level op: optional input load, then each
// mode's start pulse followed by its fixed working-cycle budget.
module coder_seq
  import kyber_coder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] req_op,
  output logic       req_ready,
  input  logic       abort,
  output logic       coder_active,
  output logic [3:0] coder_mode,
  output logic       load_enc,
  output logic       load_dec,
  output logic       coder_ram_sel,
  output logic       busy,
  output logic       done,
  output logic       err
);

  seq_state_e r_state;
  seq_state_e w_next_state;
  logic [2:0] r_op;
  logic [1:0] r_step;
  logic [6:0] r_cnt;
  logic       r_abort;

  logic [2:0] w_rom_op;
  logic       w_has_load;
  logic       w_load_is_dec;
  logic [3:0] w_mode;
  logic       w_is_last;
  logic       w_abort;
  logic       w_run_end;

  // In IDLE the incoming op is decoded so the first transition can pick LOAD or ISSUE.
  assign w_rom_op  = (r_state == S_IDLE) ? req_op : r_op;
  assign w_abort   = r_abort | abort;
  assign w_run_end = (r_cnt <= 7'd1);

  coder_step_rom u_rom (
    .i_op          (w_rom_op),
    .i_step        (r_step),
    .o_has_load    (w_has_load),
    .o_load_is_dec (w_load_is_dec),
    .o_mode        (w_mode),
    .o_is_last     (w_is_last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!req_valid)              w_next_state = S_IDLE;
        else if (!op_is_legal(req_op)) w_next_state = S_DONE;
        else if (w_has_load)         w_next_state = S_LOAD;
        else                         w_next_state = S_ISSUE;
      end
      S_LOAD:  w_next_state = w_abort ? S_DONE : S_ISSUE;
      S_ISSUE: w_next_state = S_RUN;
      S_RUN: begin
        if (!w_run_end)                  w_next_state = S_RUN;
        else if (w_abort || w_is_last)   w_next_state = S_DONE;
        else                             w_next_state = S_ISSUE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Op latch, step index, working-cycle counter and sticky abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= 3'd0;
      r_step  <= 2'd0;
      r_cnt   <= 7'd0;
      r_abort <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) r_op <= req_op;
          r_step  <= 2'd0;
          r_abort <= 1'b0;
        end
        S_LOAD: r_abort <= w_abort;
        S_ISSUE: begin
          r_cnt   <= mode_work_cycles(w_mode);
          r_abort <= w_abort;
        end
        S_RUN: begin
          r_cnt   <= r_cnt - 7'd1;
          r_abort <= w_abort;
          if (w_run_end && !w_is_last) r_step <= r_step + 2'd1;
        end
        S_DONE:  r_abort <= 1'b0;
        default: r_abort <= 1'b0;
      endcase
    end
  end

  // Output decode from registered state only
  always_comb begin
    req_ready     = 1'b0;
    coder_active  = 1'b0;
    coder_mode    = 4'd0;
    load_enc      = 1'b0;
    load_dec      = 1'b0;
    coder_ram_sel = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    err           = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_LOAD: begin
        load_enc = ~w_load_is_dec;
        load_dec = w_load_is_dec;
      end
      S_ISSUE: begin
        coder_active  = 1'b1;
        coder_mode    = w_mode;
        coder_ram_sel = 1'b1;
      end
      S_RUN: begin
        coder_mode    = w_mode;
        coder_ram_sel = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        err  = r_abort | ~op_is_legal(r_op);
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_coder_seq.sv
// Self-checking bench for coder_seq: every cycle of each op is compared against
// a timeline built from the step lists and per-mode cycle budgets.
module tb_coder_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_op;
  logic       req_ready;
  logic       abort;
  logic       coder_active;
  logic [3:0] coder_mode;
  logic       load_enc;
  logic       load_dec;
  logic       coder_ram_sel;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] w_obs;

  localparam logic [11:0] IDLE_V = 12'b1000_0000_0000;

  always #5 clk = ~clk;

  coder_seq dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_op        (req_op),
    .req_ready     (req_ready),
    .abort         (abort),
    .coder_active  (coder_active),
    .coder_mode    (coder_mode),
    .load_enc      (load_enc),
    .load_dec      (load_dec),
    .coder_ram_sel (coder_ram_sel),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  assign w_obs = {req_ready, coder_active, coder_mode, load_enc, load_dec,
                  coder_ram_sel, busy, done, err};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] vec(input bit rdy, input bit act, input logic [3:0] md,
                                      input bit le, input bit ld, input bit sel,
                                      input bit bsy, input bit dn, input bit er);
    return {rdy, act, md, le, ld, sel, bsy, dn, er};
  endfunction

  function automatic int work(input int mode);
    case (mode)
      1, 2, 3, 6: return 64;
      4, 8:       return 33;
      5, 7:       return 97;
      default:    return 0;
    endcase
  endfunction

  // Expected output vector per cycle, index 0 = the accept cycle.
  task automatic build_model(input int op, input int abort_cyc);
    int  modes[$];
    int  load;
    int  t;
    bit  ab;
    exp_q.delete();
    exp_q.push_back(IDLE_V);
    load = 0;
    case (op)
      0: begin modes.push_back(1); modes.push_back(2); end
      1: begin load = 1; modes.push_back(3); modes.push_back(4); end
      2: modes.push_back(5);
      3: begin load = 2; modes.push_back(6); modes.push_back(7); end
      4: modes.push_back(8);
      default: load = 0;
    endcase
    if (modes.size() == 0) begin
      exp_q.push_back(vec(0, 0, 4'd0, 0, 0, 0, 1, 1, 1));
    end else begin
      t  = 1;
      ab = 0;
      if (load != 0) begin
        exp_q.push_back(vec(0, 0, 4'd0, load == 1, load == 2, 0, 1, 0, 0));
        ab = (abort_cyc >= 1) && (abort_cyc <= t);
        t++;
      end
      foreach (modes[k]) begin
        if (!ab) begin
          exp_q.push_back(vec(0, 1, 4'(modes[k]), 0, 0, 1, 1, 0, 0));
          repeat (work(modes[k])) exp_q.push_back(vec(0, 0, 4'(modes[k]), 0, 0, 1, 1, 0, 0));
          t += 1 + work(modes[k]);
          ab = (abort_cyc >= 1) && (abort_cyc < t);
        end
      end
      exp_q.push_back(vec(0, 0, 4'd0, 0, 0, 0, 1, 1, ab));
    end
  endtask

  // Entered at posedge+1 with the DUT idle; returns at posedge+1 of the next ready cycle.
  task automatic run_op(input int op, input int abort_cyc, input bit hold,
                        output int done_cyc, output int n_done);
    build_model(op, abort_cyc);
    done_cyc = -1;
    n_done   = 0;
    foreach (exp_q[i]) begin
      req_valid = (i == 0) || hold;
      req_op    = 3'(op);
      abort     = (i == abort_cyc);
      @(negedge clk);
      check($sformatf("op%0d_ab%0d_cyc%0d", op, abort_cyc, i), 32'(w_obs), 32'(exp_q[i]));
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = i;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      req_valid = 1'b0;
      abort     = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle", 32'(w_obs), 32'(IDLE_V));
      @(posedge clk); #1;
    end
    abort = 1'b0;
  endtask

  initial begin
    int dc, dn, op, ab;
    bit hold;
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; abort = 1'b0;
    #2;
    check("reset_state", 32'(w_obs), 32'(IDLE_V));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_op(2, -1, 1'b0, dc, dn);
    check("enc_out_done_cyc", dc, 99);
    idle_cycles(1);
    run_op(1, -1, 1'b0, dc, dn);
    check("enc_in_done_cyc", dc, 101);
    run_op(3, -1, 1'b1, dc, dn);
    check("dec_in_done_cyc", dc, 165);
    check("dec_in_one_done", dn, 1);
    run_op(4, -1, 1'b0, dc, dn);
    check("dec_out_done_cyc", dc, 35);
    run_op(0, 10, 1'b0, dc, dn);
    check("keygen_abort_done_cyc", dc, 66);
    run_op(6, -1, 1'b1, dc, dn);
    check("illegal_done_cyc", dc, 1);
    run_op(3, 1, 1'b0, dc, dn);
    check("abort_in_load_done_cyc", dc, 2);
    run_op(2, 0, 1'b1, dc, dn);
    check("idle_abort_ignored_one_done", dn, 1);

    // Async reset in the middle of DEC_IN
    build_model(3, -1);
    for (int i = 0; i < 40; i++) begin
      req_valid = (i == 0); req_op = 3'd3; abort = 1'b0;
      @(negedge clk);
      check($sformatf("pre_rst_cyc%0d", i), 32'(w_obs), 32'(exp_q[i]));
      @(posedge clk); #1;
    end
    #1 rst = 1'b1;
    #1 check("rst_async", 32'(w_obs), 32'(IDLE_V));
    repeat (3) begin
      @(negedge clk);
      check("rst_hold", 32'(w_obs), 32'(IDLE_V));
    end
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(3, -1, 1'b0, dc, dn);
    check("post_rst_done_cyc", dc, 165);

    // Randomized ops, aborts, held requests and idle gaps
    for (int r = 0; r < 24; r++) begin
      op   = $urandom_range(0, 7);
      ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 110)) : -1;
      hold = 1'($urandom_range(0, 1));
      run_op(op, ab, hold, dc, dn);
      check($sformatf("rand%0d_one_done", r), dn, 1);
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
